// File: rtl/lsu_dmem.sv
// Load/store unit front end for an RV32I core: formats byte/half/word accesses
// onto a word-wide data memory port with handshake timeout and error reporting.
module lsu_dmem #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // rsp_valid is a single-cycle pulse with no back-pressure from the core.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        f3_legal;
  logic        misalign;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  // Request decode works on the live inputs so it can be latched at acceptance.
  always_comb begin
    f3_legal = 1'b0;
    if (req_we) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    misalign  = 1'b0;
    req_be    = 4'b1111;
    req_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        misalign  = addr[0];
        req_be    = 4'b0011 << addr[1:0];
        req_wdata = {2{wdata[15:0]}};
      end
      2'b10: begin
        misalign  = (addr[1:0] != 2'b00);
        req_be    = 4'b1111;
        req_wdata = wdata;
      end
      default: begin
        misalign  = 1'b0;
        req_be    = 4'b1111;
        req_wdata = wdata;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend per the load kind.
  always_comb begin
    lane_data = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_data = {24'h0, lane_data[7:0]};
      3'b101:  load_data = {16'h0, lane_data[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = funct3;
          lane_d  = addr[1:0];
          be_d    = req_be;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = req_wdata;
          if (!f3_legal || misalign) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 8'h0;
          end
        end
      end
      ST_ACCESS: begin
        // An ack on the expiry edge still completes the access normally.
        if (mem_ack) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : load_data;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'h0;
      we_q    <= 1'b0;
      f3_q    <= 3'h0;
      lane_q  <= 2'h0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes derive from state so reset drops them without waiting for a clock.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be_q : 4'h0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: directed cases plus randomized loads/stores scored against
// a byte-level behavioural model of the RV32I load/store rules.
module tb_lsu_dmem;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  dbg_state;

  lsu_dmem #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Expected responses as {err, rdata}; phase: 0 idle, 1 memory access, 2 response.
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  int          phase = 0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_be = 4'h0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic [31:0] hold_rdata = 32'h0;
  logic        hold_err = 1'b0;

  logic [3:0]  cap_be = 4'h0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic [31:0] cap_rdata = 32'h0;
  logic        cap_we = 1'b0;
  logic        cap_err = 1'b0;
  int          cap_req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
  endfunction

  function automatic bit aligned(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a[1:0]) % sz(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
    logic [3:0] be;
    be = 4'h0;
    for (int i = 0; i < sz(f3); i++) be[int'(a[1:0]) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] o;
    o = 32'h0;
    for (int j = 0; j < 4; j++) o[8*j +: 8] = wd[8*(j % sz(f3)) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [63:0] v;
    logic [63:0] mask;
    int n;
    n = sz(f3);
    mask = (64'd1 << (8*n)) - 64'd1;
    v = ({32'h0, rd} >> (8*int'(a[1:0]))) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(phase == 0));
    chk("mem_req", 32'(mem_req), 32'(phase == 1));
    chk("mem_we", 32'(mem_we), 32'(phase == 1 && exp_we));
    chk("mem_be", 32'(mem_be), 32'(phase == 1 ? exp_be : 4'h0));
    chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
    if (phase == 1) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, exp_wdata);
    end
    if (phase == 2 && exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      hold_err = exp_e[32];
      hold_rdata = exp_e[31:0];
    end
    chk("rsp_rdata", rsp_rdata, hold_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(hold_err));
    if (rsp_valid) begin
      cap_rdata = rsp_rdata;
      cap_err = rsp_err;
    end
    if (mem_req) begin
      cap_be = mem_be;
      cap_addr = mem_addr;
      cap_wdata = mem_wdata;
      cap_we = mem_we;
      cap_req_cycles++;
    end
  end

  // ack_at: ACCESS cycle index (from 0) in which mem_ack is high; >= TIMEOUT means never.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    cap_req_cycles = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (!legal(we, f3) || !aligned(a, f3)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      exp_we = we; exp_be = m_be(a, f3);
      exp_addr = {a[31:2], 2'b00}; exp_wdata = m_wdata(wd, f3);
      phase = 1;
      for (int n = 0; n < TIMEOUT; n++) begin
        mem_ack = (n == ack_at);
        mem_rdata = (n == ack_at) ? rd : $urandom;
        @(posedge clk); #1;
        if (n == ack_at) begin
          exp_q.push_back({1'b0, we ? 32'h0 : m_load(rd, a, f3)});
          break;
        end
        if (n == TIMEOUT - 1) exp_q.push_back({1'b1, 32'h0});
      end
    end
    phase = 2;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    @(posedge clk); #1;
    phase = 0;
    mem_ack = 1'($urandom);
  endtask

  task automatic reset_mid_access();
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400; wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ack = 1'b0;
    exp_we = 1'b0; exp_be = 4'hF; exp_addr = 32'h0000_0400; exp_wdata = 32'h0;
    phase = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    phase = 0; hold_rdata = 32'h0; hold_err = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    repeat (2) @(negedge clk);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;

    chk("model_lb", m_load(32'h80FF_1234, 32'h103, 3'b000), 32'hFFFF_FF80);
    chk("model_lhu", m_load(32'h9ABC_5678, 32'h102, 3'b101), 32'h0000_9ABC);
    chk("model_sb", m_wdata(32'h0000_00A5, 3'b000), 32'hA5A5_A5A5);
    chk("model_be", 32'(m_be(32'h102, 3'b001)), 32'h0000_000C);

    txn(1'b0, 3'b000, 32'h0000_0103, $urandom, 0, 32'h80FF_1234);
    chk("lb_be", 32'(cap_be), 32'h8);
    chk("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    chk("lb_err", 32'(cap_err), 32'h0);

    txn(1'b0, 3'b101, 32'h0000_0102, $urandom, 0, 32'h9ABC_5678);
    chk("lhu_be", 32'(cap_be), 32'hC);
    chk("lhu_rdata", cap_rdata, 32'h0000_9ABC);

    txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 2, $urandom);
    chk("sb_we", 32'(cap_we), 32'h1);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", cap_addr, 32'h0000_0200);
    chk("sb_rdata", cap_rdata, 32'h0);

    txn(1'b1, 3'b010, 32'h0000_0202, $urandom, 0, $urandom);
    chk("sw_mis_req", 32'(cap_req_cycles), 32'h0);
    chk("sw_mis_err", 32'(cap_err), 32'h1);

    txn(1'b0, 3'b010, 32'h0000_0300, $urandom, 1000, $urandom);
    chk("to_req_cycles", 32'(cap_req_cycles), 32'(TIMEOUT));
    chk("to_err", 32'(cap_err), 32'h1);
    chk("to_rdata", cap_rdata, 32'h0);

    txn(1'b0, 3'b010, 32'h0000_0304, $urandom, TIMEOUT - 1, 32'h1234_5678);
    chk("ack_wins_err", 32'(cap_err), 32'h0);
    chk("ack_wins_rdata", cap_rdata, 32'h1234_5678);

    txn(1'b0, 3'b011, 32'h0000_0308, $urandom, 0, $urandom);
    chk("illegal_err", 32'(cap_err), 32'h1);

    reset_mid_access();
    txn(1'b0, 3'b010, 32'h0000_0500, $urandom, 1, 32'hCAFE_F00D);
    chk("post_rst_rdata", cap_rdata, 32'hCAFE_F00D);
    chk("post_rst_err", 32'(cap_err), 32'h0);

    for (int t = 0; t < 300; t++) begin
      r_we = 1'($urandom);
      r_f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      if (!r_we && $urandom_range(0, 3) == 0) r_f3 = {1'b1, 2'($urandom_range(0, 1))};
      r_a = $urandom;
      txn(r_we, r_f3, r_a, $urandom, $urandom_range(0, TIMEOUT + 3), $urandom);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
